// File: rtl/nibble_acc_pkg.sv
// Shared types and default widths for the nibble-sum accumulator slice.
package nibble_acc_pkg;

    localparam int SUM_W_DEF = 4;
    localparam int ACC_W_DEF = 8;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic                 partial;
        logic [ACC_W_DEF-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/nibble_acc_fifo.sv
// Synchronous FIFO with full/empty flags; the head reads as zero while empty.
module nibble_acc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; the gated head and the count keep stale entries invisible.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/nibble_sum_acc.sv
// Groups incoming nibble sums into totals and queues them for the output port.
// Define NIBBLE_ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module nibble_sum_acc
    import nibble_acc_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int GROUP = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] in_sum,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    output logic             out_partial,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_value,
    output logic             ovf_sticky
);

    localparam int              CNT_W = $clog2(GROUP);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(GROUP - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             at_last;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_add;
    logic             push;
    logic [ACC_W:0]   push_entry;
    logic [ACC_W:0]   head_entry;
    logic             fifo_full;
    logic             fifo_empty;

    assign at_last = (cnt_q == LAST);
    assign accept  = in_valid && in_ready;
    assign sum_ext = {1'b0, acc_q} + (ACC_W+1)'(in_sum);
    assign carry   = sum_ext[ACC_W];

`ifdef NIBBLE_ACC_SATURATE_EN
    assign acc_add = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_add = sum_ext[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            RUN: begin
                if (accept) begin
                    ovf_d = ovf_q | carry;
                    if (at_last) begin
                        acc_d = '0;
                        cnt_d = '0;
                    end else begin
                        acc_d = acc_add;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (flush && cnt_q != '0) state_d = FLUSH;
                    end
                end else if (flush && cnt_q != '0) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!fifo_full) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
        endcase
    end

    // A full FIFO blocks the closing sample even if the head pops this cycle.
    always_comb begin
        in_ready   = 1'b0;
        push       = 1'b0;
        push_entry = {1'b0, acc_add};
        unique case (state_q)
            RUN: begin
                in_ready   = !(at_last && fifo_full);
                push       = accept && at_last;
                push_entry = {1'b0, acc_add};
            end
            FLUSH: begin
                push       = !fifo_full;
                push_entry = {1'b1, acc_q};
            end
        endcase
    end

    nibble_acc_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(ACC_W + 1)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (push),
        .wr_data(push_entry),
        .rd_en  (out_ready),
        .rd_data(head_entry),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign out_partial = head_entry[ACC_W];
    assign out_data    = head_entry[ACC_W-1:0];
    assign acc_value   = acc_q;
    assign ovf_sticky  = ovf_q;

endmodule
